// File: rtl/pc_cfr_peak_detector.sv
// PC-CFR peak detector: finds local magnitude maxima in a NUM_PHASES-wide polar
// sample stream, applies sample-granular blanking and emits the excess over the clip level.
module pc_cfr_peak_detector #(
    parameter int DATA_WIDTH  = 16,
    parameter int THETA_WIDTH = 8,
    parameter int NUM_PHASES  = 2,
    parameter int BLANK_WIDTH = 8,
    parameter int PW          = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PHASES*(DATA_WIDTH+1)-1:0]  data_r_in,
    input  logic [NUM_PHASES*THETA_WIDTH-1:0]     data_theta_in,
    input  logic                                  ctrl_enable,
    input  logic [DATA_WIDTH:0]                   ctrl_pd_threshold,
    input  logic [DATA_WIDTH:0]                   ctrl_clipping_threshold,
    input  logic [BLANK_WIDTH-1:0]                ctrl_blank_len,
    input  logic                                  ctrl_count_clear,
    output logic [DATA_WIDTH:0]                   peak_r,
    output logic [THETA_WIDTH-1:0]                peak_theta,
    output logic [PW-1:0]                         peak_phase,
    output logic                                  peak_valid,
    output logic [31:0]                           peak_count
);

    localparam int RW  = DATA_WIDTH + 1;
    localparam int NP  = NUM_PHASES;
    localparam int BRW = BLANK_WIDTH + 1;
    localparam int RV  = NP * RW;
    localparam int TV  = NP * THETA_WIDTH;

    // S1: input word plus the centre word held back one clock, so that the
    // following word's phase 0 is available as lookahead for the last phase.
    logic [RV-1:0] s1_r_q;
    logic [TV-1:0] s1_theta_q;
    logic [RV-1:0] ctr_r_q;
    logic [TV-1:0] ctr_theta_q;
    logic [RW-1:0] hist_r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r_q      <= '0;
            s1_theta_q  <= '0;
            ctr_r_q     <= '0;
            ctr_theta_q <= '0;
            hist_r_q    <= '0;
        end else begin
            s1_r_q      <= data_r_in;
            s1_theta_q  <= data_theta_in;
            ctr_r_q     <= s1_r_q;
            ctr_theta_q <= s1_theta_q;
            hist_r_q    <= ctr_r_q[RV-1 -: RW];
        end
    end

    // S2: per-phase local-maximum test; >= on the left makes the last plateau sample win.
    logic [NP-1:0] cand_d;

    for (genvar p = 0; p < NP; p++) begin : g_cand
        logic [RW-1:0] cur;
        logic [RW-1:0] prv;
        logic [RW-1:0] nxt;

        assign cur = ctr_r_q[p*RW +: RW];

        if (p == 0) begin : g_first
            assign prv = hist_r_q;
        end else begin : g_prev
            assign prv = ctr_r_q[(p-1)*RW +: RW];
        end

        if (p == NP - 1) begin : g_last
            assign nxt = s1_r_q[RW-1:0];
        end else begin : g_next
            assign nxt = ctr_r_q[(p+1)*RW +: RW];
        end

        assign cand_d[p] = (cur > ctrl_pd_threshold) && (cur >= prv) && (cur > nxt);
    end

    logic [NP-1:0] s2_cand_q;
    logic [RV-1:0] s2_r_q;
    logic [TV-1:0] s2_theta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_cand_q  <= '0;
            s2_r_q     <= '0;
            s2_theta_q <= '0;
        end else begin
            s2_cand_q  <= cand_d;
            s2_r_q     <= ctr_r_q;
            s2_theta_q <= ctr_theta_q;
        end
    end

    // S3: pick the largest unblanked candidate; ascending scan with strict '>'
    // keeps the lowest phase on equal magnitudes.
    logic                   sel_found;
    logic [PW-1:0]          sel_idx;
    logic [RW-1:0]          sel_r;
    logic [THETA_WIDTH-1:0] sel_theta;
    logic [BRW-1:0]         blank_rem_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_r     = '0;
        sel_theta = '0;
        for (int p = 0; p < NP; p++) begin
            if (s2_cand_q[p] && (p >= int'(blank_rem_q)) &&
                (!sel_found || (s2_r_q[p*RW +: RW] > sel_r))) begin
                sel_found = 1'b1;
                sel_idx   = PW'(p);
                sel_r     = s2_r_q[p*RW +: RW];
                sel_theta = s2_theta_q[p*THETA_WIDTH +: THETA_WIDTH];
            end
        end
    end

    logic                   emit;
    logic [31:0]            tail;
    logic [31:0]            len_ext;
    logic [BRW-1:0]         blank_d;
    logic [RW-1:0]          excess_d;
    logic [31:0]            count_q;
    logic [31:0]            count_d;
    logic                   valid_q;
    logic [RW-1:0]          pr_q;
    logic [THETA_WIDTH-1:0] theta_q;
    logic [PW-1:0]          phase_q;

    always_comb begin
        emit    = ctrl_enable & sel_found;
        // Samples of the emitting clock after the peak already count against the window.
        tail    = 32'(NP - 1) - 32'(sel_idx);
        len_ext = 32'(ctrl_blank_len);
        blank_d = '0;
        if (!ctrl_enable) begin
            blank_d = '0;
        end else if (emit) begin
            blank_d = (len_ext > tail) ? BRW'(len_ext - tail) : '0;
        end else begin
            blank_d = (blank_rem_q > BRW'(NP)) ? (blank_rem_q - BRW'(NP)) : '0;
        end

        excess_d = (sel_r > ctrl_clipping_threshold) ? (sel_r - ctrl_clipping_threshold) : '0;

        count_d = count_q;
        if (ctrl_count_clear) begin
            count_d = '0;
        end else if (emit && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_rem_q <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            pr_q        <= '0;
            theta_q     <= '0;
            phase_q     <= '0;
        end else begin
            blank_rem_q <= blank_d;
            count_q     <= count_d;
            valid_q     <= emit;
            pr_q        <= emit ? excess_d : '0;
            theta_q     <= emit ? sel_theta : '0;
            phase_q     <= emit ? sel_idx : '0;
        end
    end

    assign peak_valid = valid_q;
    assign peak_r     = pr_q;
    assign peak_theta = theta_q;
    assign peak_phase = phase_q;
    assign peak_count = count_q;

endmodule

// File: tb/tb_pc_cfr_peak_detector.sv
// Bench for pc_cfr_peak_detector: a 2-phase and a 4-phase instance checked every
// cycle against a stream-level model, plus literal expectations for directed cases.
module tb_pc_cfr_peak_detector;

    localparam int RW   = 17;
    localparam int TW   = 8;
    localparam int BW   = 8;
    localparam int MAXC = 400;
    localparam int SLEN = MAXC * 4 + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*RW-1:0] r2_in;
    logic [2*TW-1:0] t2_in;
    logic [4*RW-1:0] r4_in;
    logic [4*TW-1:0] t4_in;
    logic            en;
    logic            clr;
    logic [RW-1:0]   pd;
    logic [RW-1:0]   clip;
    logic [BW-1:0]   blen;

    logic [RW-1:0] pr2, pr4;
    logic [TW-1:0] th2, th4;
    logic [0:0]    ph2;
    logic [1:0]    ph4;
    logic          v2, v4;
    logic [31:0]   cnt2, cnt4;

    pc_cfr_peak_detector #(.DATA_WIDTH(16), .THETA_WIDTH(TW), .NUM_PHASES(2), .BLANK_WIDTH(BW)) u2 (
        .clk(clk), .rst(rst), .data_r_in(r2_in), .data_theta_in(t2_in),
        .ctrl_enable(en), .ctrl_pd_threshold(pd), .ctrl_clipping_threshold(clip),
        .ctrl_blank_len(blen), .ctrl_count_clear(clr),
        .peak_r(pr2), .peak_theta(th2), .peak_phase(ph2), .peak_valid(v2), .peak_count(cnt2)
    );

    pc_cfr_peak_detector #(.DATA_WIDTH(16), .THETA_WIDTH(TW), .NUM_PHASES(4), .BLANK_WIDTH(BW)) u4 (
        .clk(clk), .rst(rst), .data_r_in(r4_in), .data_theta_in(t4_in),
        .ctrl_enable(en), .ctrl_pd_threshold(pd), .ctrl_clipping_threshold(clip),
        .ctrl_blank_len(blen), .ctrl_count_clear(clr),
        .peak_r(pr4), .peak_theta(th4), .peak_phase(ph4), .peak_valid(v4), .peak_count(cnt4)
    );

    // Stimulus as flat sample streams (index n) per instance, plus per-clock controls.
    logic [RW-1:0] rs [2][SLEN];
    logic [TW-1:0] ts [2][SLEN];
    bit            en_h [MAXC];
    bit            clr_h [MAXC];

    int          checks = 0;
    int          failures = 0;
    int          sup [2];
    logic [31:0] mcnt [2];
    int          cyc = 0;
    bit          run = 1'b0;
    int          force_at = -1;
    logic [31:0] cnt0_at [MAXC];

    typedef struct {
        int c;
        int ph;
        int pr;
        int th;
    } em_t;
    em_t em0[$];
    em_t em1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected emission for the word whose decision lands at clock c, in stream terms:
    // local maximum above pd, not within L samples after the previous emitted peak.
    task automatic model_word(input int d, input int c, output bit v, output int pr,
                              output int th, output int ph);
        int np;
        int w;
        int best;
        int pdi;
        np   = (d != 0) ? 4 : 2;
        w    = c - 3;
        best = -1;
        pdi  = int'(pd);
        v = 1'b0; pr = 0; th = 0; ph = 0;
        if (!en_h[c]) begin
            sup[d] = -1;
        end else if (w >= 0) begin
            for (int p = 0; p < np; p++) begin
                int n, cur, prv, nxt;
                n   = w * np + p;
                cur = int'(rs[d][n]);
                prv = (n == 0) ? 0 : int'(rs[d][n-1]);
                nxt = int'(rs[d][n+1]);
                if (cur > pdi && cur >= prv && cur > nxt && n > sup[d]) begin
                    if (best < 0 || cur > int'(rs[d][best])) best = n;
                end
            end
            if (best >= 0) begin
                v      = 1'b1;
                sup[d] = best + int'(blen);
                ph     = best - w * np;
                th     = int'(ts[d][best]);
                pr     = (rs[d][best] > clip) ? int'(rs[d][best]) - int'(clip) : 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (run) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                bit          ev;
                int          epr, eth, eph;
                logic        dv;
                logic [31:0] dpr, dth, dph, dcnt;
                em_t         e;
                if (d == 0) begin
                    dv = v2; dpr = 32'(pr2); dth = 32'(th2); dph = 32'(ph2); dcnt = cnt2;
                end else begin
                    dv = v4; dpr = 32'(pr4); dth = 32'(th4); dph = 32'(ph4); dcnt = cnt4;
                end
                model_word(d, cyc, ev, epr, eth, eph);
                if (clr_h[cyc]) mcnt[d] = 32'd0;
                else if (ev && mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 32'd1;
                chk($sformatf("u%0d valid c%0d", d, cyc), 64'(dv), 64'(ev));
                if (ev && dv) begin
                    chk($sformatf("u%0d peak_r c%0d", d, cyc), 64'(dpr), 64'(epr));
                    chk($sformatf("u%0d theta c%0d", d, cyc), 64'(dth), 64'(eth));
                    chk($sformatf("u%0d phase c%0d", d, cyc), 64'(dph), 64'(eph));
                end
                chk($sformatf("u%0d count c%0d", d, cyc), 64'(dcnt), 64'(mcnt[d]));
                if (dv) begin
                    e.c = cyc; e.ph = int'(dph); e.pr = int'(dpr); e.th = int'(dth);
                    if (d == 0) em0.push_back(e);
                    else em1.push_back(e);
                end
                if (d == 0) cnt0_at[cyc] = dcnt;
            end
            cyc++;
        end
    end

    task automatic drive(input int c);
        en  = en_h[c];
        clr = clr_h[c];
        for (int p = 0; p < 2; p++) begin
            r2_in[p*RW +: RW] = rs[0][c*2+p];
            t2_in[p*TW +: TW] = ts[0][c*2+p];
        end
        for (int p = 0; p < 4; p++) begin
            r4_in[p*RW +: RW] = rs[1][c*4+p];
            t4_in[p*TW +: TW] = ts[1][c*4+p];
        end
    endtask

    task automatic fill_const(input int val);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < SLEN; n++) begin
                rs[d][n] = RW'(val);
                ts[d][n] = TW'(n);
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            en_h[c]  = 1'b1;
            clr_h[c] = 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < SLEN; n++) begin
                int m;
                m = int'($urandom_range(0, 9));
                if (m <= 5)      rs[d][n] = RW'($urandom_range(0, int'(pd)));
                else if (m <= 7) rs[d][n] = RW'($urandom_range(0, 131071));
                else if (m == 8) rs[d][n] = (n > 0) ? rs[d][n-1] : '0;
                else             rs[d][n] = pd + RW'($urandom_range(0, 1));
                ts[d][n] = TW'($urandom);
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            en_h[c]  = ($urandom_range(0, 19) != 0);
            clr_h[c] = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic run_seg(input int ncyc);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sup[0] = -1; sup[1] = -1;
        mcnt[0] = '0; mcnt[1] = '0;
        cyc = 0;
        em0.delete();
        em1.delete();
        rst = 1'b0;
        run = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == force_at) begin
                force u2.count_q = 32'hFFFF_FFFE;
                mcnt[0] = 32'hFFFF_FFFE;
            end
            if (c == force_at + 1) release u2.count_q;
            drive(c);
            @(negedge clk);
        end
        run = 1'b0;
    endtask

    initial begin
        en = 1'b0; clr = 1'b0; pd = '0; clip = '0; blen = '0;
        r2_in = '0; t2_in = '0; r4_in = '0; t4_in = '0;
        #12;
        chk("reset valid2", 64'(v2), 64'd0);
        chk("reset count2", 64'(cnt2), 64'd0);
        chk("reset valid4", 64'(v4), 64'd0);
        chk("reset peak_r4", 64'(pr4), 64'd0);

        // Spike, plateau, threshold edges (2-phase); same-clock selection (4-phase).
        pd = 17'd1000; clip = 17'd3000; blen = 8'd0;
        fill_const(100);
        rs[0][10] = 17'd5000; ts[0][10] = 8'h35;
        rs[0][29] = 17'd4000; rs[0][30] = 17'd4000; rs[0][31] = 17'd4000;
        rs[0][50] = 17'd1000;
        rs[0][70] = 17'd1001;
        rs[1][20] = 17'd3000; rs[1][22] = 17'd5000;
        rs[1][40] = 17'd5000; rs[1][42] = 17'd5000;
        run_seg(45);
        chk("A u2 peaks", 64'(em0.size()), 64'd3);
        if (em0.size() == 3) begin
            chk("A spike cycle", 64'(em0[0].c), 64'd8);
            chk("A spike peak_r", 64'(em0[0].pr), 64'd2000);
            chk("A spike phase", 64'(em0[0].ph), 64'd0);
            chk("A spike theta", 64'(em0[0].th), 64'h35);
            chk("A plateau cycle", 64'(em0[1].c), 64'd18);
            chk("A plateau phase", 64'(em0[1].ph), 64'd1);
            chk("A plateau theta", 64'(em0[1].th), 64'd31);
            chk("A 1001 cycle", 64'(em0[2].c), 64'd38);
            chk("A 1001 peak_r", 64'(em0[2].pr), 64'd0);
        end
        chk("A spike count", 64'(cnt0_at[8]), 64'd1);
        chk("A final count", 64'(cnt0_at[44]), 64'd3);
        chk("A u4 peaks", 64'(em1.size()), 64'd2);
        if (em1.size() == 2) begin
            chk("A sel phase", 64'(em1[0].ph), 64'd2);
            chk("A sel cycle", 64'(em1[0].c), 64'd8);
            chk("A tie phase", 64'(em1[1].ph), 64'd0);
            chk("A tie theta", 64'(em1[1].th), 64'd40);
        end

        // Blanking L=4 over maxima at n=10,13,16, then L=0.
        for (int pass = 0; pass < 2; pass++) begin
            blen = (pass == 0) ? 8'd4 : 8'd0;
            fill_const(100);
            for (int d = 0; d < 2; d++) begin
                rs[d][10] = 17'd5000; rs[d][13] = 17'd5000; rs[d][16] = 17'd5000;
            end
            run_seg(30);
            if (pass == 0) begin
                chk("B u2 peaks", 64'(em0.size()), 64'd2);
                if (em0.size() == 2) begin
                    chk("B u2 first", 64'(em0[0].c), 64'd8);
                    chk("B u2 second", 64'(em0[1].c), 64'd11);
                end
                chk("B u4 peaks", 64'(em1.size()), 64'd2);
                if (em1.size() == 2) chk("B u4 second", 64'(em1[1].c), 64'd7);
            end else begin
                chk("C u2 peaks", 64'(em0.size()), 64'd3);
                chk("C u4 peaks", 64'(em1.size()), 64'd3);
            end
        end

        // Enable gating, count saturation and clear priority.
        blen = 8'd0;
        fill_const(100);
        rs[0][10] = 17'd5000; rs[0][30] = 17'd5000; rs[0][50] = 17'd5000;
        rs[0][70] = 17'd5000; rs[0][90] = 17'd5000;
        en_h[8] = 1'b0;
        clr_h[48] = 1'b1;
        force_at = 12;
        run_seg(55);
        force_at = -1;
        chk("D u2 peaks", 64'(em0.size()), 64'd4);
        if (em0.size() == 4) chk("D first peak", 64'(em0[0].c), 64'd18);
        chk("D disabled count", 64'(cnt0_at[8]), 64'd0);
        chk("D sat count 1", 64'(cnt0_at[18]), 64'hFFFF_FFFF);
        chk("D sat count 3", 64'(cnt0_at[38]), 64'hFFFF_FFFF);
        chk("D clear wins", 64'(cnt0_at[48]), 64'd0);

        // Asynchronous reset one clock after a spike enters.
        fill_const(100);
        rs[0][2] = 17'd5000;
        rs[0][10] = 17'd5000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive(c);
            @(negedge clk);
        end
        chk("E count before rst", 64'(cnt2), 64'd1);
        rst = 1'b1;
        #1;
        chk("E rst valid", 64'(v2), 64'd0);
        chk("E rst count", 64'(cnt2), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(0);
            @(posedge clk);
            #1;
            chk($sformatf("E post-rst valid %0d", c), 64'(v2), 64'd0);
            @(negedge clk);
        end
        chk("E peak_r", 64'(pr2), 64'd0);
        chk("E theta", 64'(th2), 64'd0);
        chk("E phase", 64'(ph2), 64'd0);
        chk("E count", 64'(cnt2), 64'd0);

        // Randomised segments.
        for (int s = 0; s < 6; s++) begin
            pd   = RW'($urandom_range(200, 5000));
            clip = RW'($urandom_range(0, 8000));
            if (s == 5)                          blen = 8'd200;
            else if ($urandom_range(0, 3) == 0)  blen = 8'd0;
            else                                 blen = BW'($urandom_range(1, 12));
            fill_random();
            run_seg(300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_cfr_peak_detector.md
# pc_cfr_peak_detector

Parametrised peak detector for the PC-CFR datapath. It takes NUM_PHASES polar samples per clock (magnitude r, angle theta) from the cart2pol stage and finds local magnitude maxima above a detection threshold across the serialised sample stream. It keeps at most one peak per clock, enforces a programmable sample-granular blanking window, and emits the peak excess over the clipping threshold to the pol2cart/soft-clipper stage. It supersedes the fixed 2-phase detector: phase count is generalised, and blanking and peak statistics are new.

## Interface
- DATA_WIDTH, 16, signed I/Q width; magnitudes are DATA_WIDTH+1 bits unsigned
- THETA_WIDTH, 8, angle word width (CORDIC iterations + 1)
- NUM_PHASES, 2, samples per clock (≥2); phase 0 is the earliest sample
- BLANK_WIDTH, 8, width of blanking length
- PW, max(1,$clog2(NUM_PHASES)), derived phase index width
- clk  in  1  datapath clock
- rst  in  1  asynchronous, active-high reset
- data_r_in  in  NUM_PHASES*(DATA_WIDTH+1)  magnitudes; phase p at slice p
- data_theta_in  in  NUM_PHASES*THETA_WIDTH  angles, same packing
- ctrl_enable  in  1  1 = detect, 0 = no peaks
- ctrl_pd_threshold  in  DATA_WIDTH+1  detection threshold (unsigned)
- ctrl_clipping_threshold  in  DATA_WIDTH+1  clipping target (unsigned)
- ctrl_blank_len  in  BLANK_WIDTH  samples suppressed after an emitted peak
- ctrl_count_clear  in  1  synchronous clear of peak_count
- peak_r  out  DATA_WIDTH+1  saturating excess r − clipping_threshold
- peak_theta  out  THETA_WIDTH  angle of the selected sample
- peak_phase  out  PW  phase index of the selected sample
- peak_valid  out  1  single-cycle peak strobe
- peak_count  out  32  number of emitted peaks, saturating

## Operation
- Stream index n = k*NUM_PHASES + p (clock k, phase p).
- Candidate at n: r[n] > pd_threshold AND r[n] ≥ r[n−1] AND r[n] > r[n+1]. On a plateau the last sample wins.
- r[n−1] for phase 0 comes from the previous clock's last phase. r[n+1] for the last phase comes from the next clock's phase 0, so there is one clock of lookahead. After reset the history sample is 0.
- Selection per clock: the candidate with the largest r is chosen. On equal r the lowest phase wins. Other candidates in the same clock are discarded.
- Blanking: register blank_rem (BLANK_WIDTH+1 bits, reset 0).
  - A candidate at phase q is suppressed if q < blank_rem.
  - After a clock with no emission: blank_rem ← max(blank_rem − NUM_PHASES, 0).
  - After emitting at phase p: blank_rem ← max(ctrl_blank_len − (NUM_PHASES−1−p), 0).
  - Net effect: samples n+1..n+L are suppressed. L = 0 disables blanking.
- Output: peak_r = r − clipping_threshold if r > clipping_threshold, else 0. peak_valid still asserts when r ≤ clipping_threshold. peak_theta and peak_phase belong to the selected sample.
- ctrl_enable = 0: candidates are masked, peak_valid = 0, blank_rem is forced to 0, peak_count is held.
- peak_count increments on each peak_valid and saturates at 0xFFFFFFFF. ctrl_count_clear has priority over increment (clear wins in the same cycle).
- All control inputs are already synchronous to clk (CDC is done upstream).

## Timing
- Three register stages:
  - S1: input register.
  - S2: candidate compare, using the S1 lookahead.
  - S3: selection, blanking, subtraction, output register.
- A sample presented on the edge of clock k appears on peak_* at clock k+3, fixed and independent of phase. The downstream delay line must match 3.
- Full throughput: one clock per NUM_PHASES samples, no stalls, no backpressure.
- peak_valid lasts exactly one cycle per emitted peak. Peaks can occur in consecutive clocks when blank_len = 0.
- Reset values: peak_valid 0, peak_r 0, peak_theta 0, peak_phase 0, peak_count 0, blank_rem 0, history and pipeline registers 0.
- Reset asserted mid-operation forces all outputs to 0 immediately. No peak is emitted after release from data captured before reset.
- ctrl_enable falling takes effect on the S3 decision in the same cycle. Rising takes effect at the next S3 decision; there is no retroactive emission.

## Test plan
- Single spike (NUM_PHASES=2, pd 1000, clip 3000, L 0): r=100 everywhere, n=10 r=5000 θ=0x35 -> one peak_valid at clock 5+3=8, peak_r 2000, phase 0, θ 0x35, peak_count 1.
- Plateau and threshold edges: n=9..11 r=4000 -> single peak at n=11 (phase 1). A lone r=1000 gives no peak. A lone r=1001 gives a peak with peak_r 0.
- Same-clock selection (NUM_PHASES=4): phase 0 r=3000 and phase 2 r=5000 -> only phase 2 emitted. With both at 5000 -> phase 0 emitted.
- Blanking (NUM_PHASES=2, L=4): isolated maxima at n=10, 13, 16 -> peaks at 10 and 16 only. With L=0 -> all three are emitted.
- Enable and count: ctrl_enable=0 during a spike -> no strobe, count unchanged. Force count to 0xFFFFFFFE, then 3 peaks -> count holds 0xFFFFFFFF. ctrl_count_clear coincident with a peak -> count 0.
- Async reset: assert rst one clock after a spike enters -> peak_valid stays 0 through and after release, all outputs read 0.
